multibyte_alu_sequencer: RTL

Sequences the shared 8-bit ALU to perform NBYTES-wide arithmetic and logic operations, processing one byte per clock from least significant to most significant. Carry and borrow are chained between bytes through the ALU carry input. The block sits between the instruction/control path, which issues start with wide operands, and the 8-bit ALU instance, whose ports it drives.

---
 rtl/multibyte_alu_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/multibyte_alu_sequencer.sv
// Drives a shared 8-bit ALU one byte per clock, LSB first, to build NBYTES-wide
// arithmetic/logic results with carry/borrow chained between bytes.
module multibyte_alu_sequencer #(
    parameter int NBYTES = 4,
    parameter int IDXW   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            operation,
    input  logic                  carryIn,
    input  logic [8*NBYTES-1:0]   operandA,
    input  logic [8*NBYTES-1:0]   operandB,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carryOut,
    output logic                  zero,
    output logic [7:0]            aluInputA,
    output logic [7:0]            aluInputB,
    output logic                  aluCarryIn,
    output logic [2:0]            aluOperation,
    input  logic [7:0]            aluResult,
    input  logic                  aluCarryOut
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    state_t               stateNext;
    logic [IDXW-1:0]      idx;
    logic [8*NBYTES-1:0]  latA;
    logic [8*NBYTES-1:0]  latB;
    logic [2:0]           latOp;
    logic                 latCin;
    logic                 carry;
    logic [8*NBYTES-1:0]  acc;
    logic [8*NBYTES-1:0]  accNext;
    logic                 lastByte;
    logic                 isLogic;

    assign lastByte = (idx == IDXW'(NBYTES - 1));
    assign isLogic  = latOp[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = RUN;
            RUN:     if (lastByte) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        aluInputA    = '0;
        aluInputB    = '0;
        aluCarryIn   = 1'b0;
        aluOperation = '0;
        case (state)
            RUN: begin
                busy      = 1'b1;
                aluInputA = latA[idx*8 +: 8];
                aluInputB = latB[idx*8 +: 8];
                if (isLogic) begin
                    aluOperation = latOp;
                    aluCarryIn   = 1'b0;
                end else if (idx == '0) begin
                    // ADC/SBB take the external carry; ADD/SUB start with none
                    aluOperation = latOp;
                    aluCarryIn   = latOp[0] ? latCin : 1'b0;
                end else begin
                    aluOperation = latOp | 3'b001;
                    aluCarryIn   = carry;
                end
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Accumulator with the current byte merged, so the final edge sees all bytes
    always_comb begin
        accNext = acc;
        accNext[idx*8 +: 8] = aluResult;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            latA     <= '0;
            latB     <= '0;
            latOp    <= '0;
            latCin   <= 1'b0;
            carry    <= 1'b0;
            acc      <= '0;
            result   <= '0;
            carryOut <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        latA   <= operandA;
                        latB   <= operandB;
                        latOp  <= operation;
                        latCin <= carryIn;
                        idx    <= '0;
                        carry  <= 1'b0;
                        acc    <= '0;
                    end
                end
                RUN: begin
                    acc   <= accNext;
                    carry <= aluCarryOut;
                    idx   <= idx + IDXW'(1);
                    if (lastByte) begin
                        idx      <= '0;
                        result   <= accNext;
                        carryOut <= isLogic ? 1'b0 : aluCarryOut;
                        zero     <= (accNext == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
